// File: rtl/imm_narrow.sv
// imm_narrow: splits a 16-bit constant into the shortest sequence of 9-bit
// immediate fields. Values in -256..255 go out as one sign-extendable FULL
// beat. Anything wider goes out as a HIGH beat followed by a LOW beat.
// Valid/ready handshakes are used on both the input and the output side.
module imm_narrow (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  out_immed,
    output logic [1:0]  out_kind,
    output logic        out_last,
    output logic [15:0] split_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FULL = 2'b01,
        S_HI   = 2'b10,
        S_LO   = 2'b11
    } state_t;

    localparam logic [1:0] KIND_FULL = 2'b00;
    localparam logic [1:0] KIND_HIGH = 2'b01;
    localparam logic [1:0] KIND_LOW  = 2'b10;

    state_t             state;
    logic signed [15:0] value_s;
    logic [8:0]         lo_p0;
    logic               accept;
    logic               beat_taken;

    // A value fits when it lies within the signed 9-bit range.
    function automatic logic fits_imm9(input logic signed [15:0] v);
        return (v >= -16'sd256) && (v <= 16'sd255);
    endfunction

    // Increment the counter, but hold it at its maximum value once reached.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign value_s    = in_value;
    assign in_ready   = (state == S_IDLE);
    assign accept     = in_valid && in_ready;
    assign beat_taken = out_valid && out_ready;

    // Hold the low nine bits of an accepted value until the LOW beat is sent.
    always_ff @(posedge clk) begin
        if (accept) begin
            lo_p0 <= in_value[8:0];
        end
    end

    // Sequencer with registered outputs. The outputs stay frozen while the
    // consumer is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            out_valid   <= 1'b0;
            out_immed   <= 9'd0;
            out_kind    <= KIND_FULL;
            out_last    <= 1'b0;
            split_count <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        out_valid <= 1'b1;
                        if (fits_imm9(value_s)) begin
                            state     <= S_FULL;
                            out_immed <= in_value[8:0];
                            out_kind  <= KIND_FULL;
                            out_last  <= 1'b1;
                        end else begin
                            state       <= S_HI;
                            out_immed   <= {2'b00, in_value[15:9]};
                            out_kind    <= KIND_HIGH;
                            out_last    <= 1'b0;
                            split_count <= sat_inc(split_count);
                        end
                    end
                end
                S_HI: begin
                    if (beat_taken) begin
                        state     <= S_LO;
                        out_immed <= lo_p0;
                        out_kind  <= KIND_LOW;
                        out_last  <= 1'b1;
                    end
                end
                S_FULL, S_LO: begin
                    if (beat_taken) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_narrow.sv
// tb_imm_narrow: scoreboard bench for imm_narrow. Expected beats are queued
// when a value is offered. A monitor pops and compares each beat on handshake.
module tb_imm_narrow;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_immed;
    logic [1:0]  out_kind;
    logic        out_last;
    logic [15:0] split_count;

    typedef struct {
        logic [8:0]  immed;
        logic [1:0]  kind;
        logic        last;
        logic [15:0] value;
    } beat_t;

    beat_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [15:0] exp_sc = 16'd0;
    logic [8:0]  hi_seen = 9'd0;
    logic [15:0] rec;
    beat_t       e;

    imm_narrow dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_immed   (out_immed),
        .out_kind    (out_kind),
        .out_last    (out_last),
        .split_count (split_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compares every completed output beat.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got immed=%h kind=%b last=%b, none expected",
                             out_immed, out_kind, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_immed, out_kind, out_last} !== {e.immed, e.kind, e.last}) begin
                        errors++;
                        $display("FAIL beat(%h) got immed=%h kind=%b last=%b, want immed=%h kind=%b last=%b",
                                 e.value, out_immed, out_kind, out_last, e.immed, e.kind, e.last);
                    end
                    if (out_kind === 2'b01) hi_seen = out_immed;
                    if (e.last) begin
                        checks++;
                        if (out_kind === 2'b00) rec = {{7{out_immed[8]}}, out_immed};
                        else                    rec = {hi_seen[6:0], out_immed};
                        if (rec !== e.value) begin
                            errors++;
                            $display("FAIL reconstruct got %h, want %h", rec, e.value);
                        end
                    end
                end
            end
        end
    end

    // Reference model: queue the expected beats for a value.
    task automatic push_expected(input logic [15:0] v);
        if (v[15:8] == 8'h00 || v[15:8] == 8'hFF) begin
            exp_q.push_back('{immed: v[8:0], kind: 2'b00, last: 1'b1, value: v});
        end else begin
            exp_q.push_back('{immed: {2'b00, v[15:9]}, kind: 2'b01, last: 1'b0, value: v});
            exp_q.push_back('{immed: v[8:0], kind: 2'b10, last: 1'b1, value: v});
            if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
        end
    endtask

    // Offer one value and wait until it is accepted. The task is entered and
    // left just after a rising edge.
    task automatic send(input logic [15:0] v);
        int   n;
        logic acc;
        push_expected(v);
        in_value = v;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        acc_cyc = cyc;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout value=%h not accepted within %0d cycles", v, n);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d out_valid=%b, want 0 and 0", exp_q.size(), out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_immed !== 9'd0) begin errors++; $display("FAIL reset_immed got %h want 0", out_immed); end
        checks++;
        if (out_kind !== 2'b00) begin errors++; $display("FAIL reset_kind got %b want 00", out_kind); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
        checks++;
        if (split_count !== 16'd0) begin errors++; $display("FAIL reset_split_count got %h want 0", split_count); end
        exp_sc = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fit();
        out_ready = 1'b1;
        send(16'h0001);
        checks++;
        if ({out_valid, out_immed, out_kind, out_last, in_ready} !== {1'b1, 9'h001, 2'b00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fit_latency got v=%b immed=%h kind=%b last=%b rdy=%b, want 1 001 00 1 0",
                     out_valid, out_immed, out_kind, out_last, in_ready);
        end
        wait_idle();
        send(16'hFF00);
        checks++;
        if (out_immed !== 9'h100) begin errors++; $display("FAIL fit_neg_immed got %h want 100", out_immed); end
        wait_idle();
        checks++;
        if (split_count !== 16'd0) begin errors++; $display("FAIL fit_split_count got %h want 0", split_count); end
    endtask

    task automatic test_split();
        out_ready = 1'b1;
        send(16'h1234);
        checks++;
        if ({out_immed, out_kind, out_last} !== {9'h009, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL split_hi got immed=%h kind=%b last=%b want 009 01 0", out_immed, out_kind, out_last);
        end
        wait_idle();
        checks++;
        if (split_count !== 16'd1) begin errors++; $display("FAIL split_count_one got %h want 1", split_count); end
        send(16'h8000);
        wait_idle();
        checks++;
        if (split_count !== exp_sc) begin errors++; $display("FAIL split_count got %h want %h", split_count, exp_sc); end
    endtask

    task automatic test_boundaries();
        logic [15:0] vals [6];
        vals = '{16'h00FF, 16'h0100, 16'hFEFF, 16'hFF00, 16'hFFFF, 16'h7FFF};
        out_ready = 1'b1;
        foreach (vals[i]) begin
            send(vals[i]);
            wait_idle();
        end
        checks++;
        if (split_count !== exp_sc) begin errors++; $display("FAIL boundary_split_count got %h want %h", split_count, exp_sc); end
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        out_ready = 1'b1;
        send(16'h0010);
        c0 = acc_cyc;
        send(16'h2000);
        c1 = acc_cyc;
        checks++;
        if (c1 - c0 !== 2) begin errors++; $display("FAIL throughput_fit got %0d cycles want 2", c1 - c0); end
        send(16'hFFF0);
        checks++;
        if (acc_cyc - c1 !== 3) begin errors++; $display("FAIL throughput_split got %0d cycles want 3", acc_cyc - c1); end
        wait_idle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(16'h1234);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_immed, out_kind, out_last, in_ready} !== {1'b1, 9'h009, 2'b01, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%b immed=%h kind=%b last=%b rdy=%b, want 1 009 01 0 0",
                         i, out_valid, out_immed, out_kind, out_last, in_ready);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_immed, out_kind, out_last} !== {1'b1, 9'h034, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL stall_release_lo got v=%b immed=%h kind=%b last=%b, want 1 034 10 1",
                     out_valid, out_immed, out_kind, out_last);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(16'h1234);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
        checks++;
        if (split_count !== 16'd0) begin errors++; $display("FAIL midreset_split_count got %h want 0", split_count); end
        exp_q.delete();
        exp_sc = 16'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        send(16'h0005);
        checks++;
        if ({out_kind, out_last, out_immed} !== {2'b00, 1'b1, 9'h005}) begin
            errors++;
            $display("FAIL midreset_next got kind=%b last=%b immed=%h want 00 1 005", out_kind, out_last, out_immed);
        end
        wait_idle();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        force dut.split_count = 16'hFFFE;
        @(negedge clk);
        release dut.split_count;
        exp_sc = 16'hFFFE;
        @(posedge clk);
        #1;
        send(16'h1234);
        wait_idle();
        checks++;
        if (split_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want FFFF", split_count); end
        send(16'h4000);
        wait_idle();
        checks++;
        if (split_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want FFFF", split_count); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_value = 16'd0;
        out_ready = 1'b1;
        test_reset();
        test_fit();
        test_split();
        test_boundaries();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
